// File: rtl/time_report_tx.sv
// time_report_tx
// Snapshots the time fields on a trigger and streams them into the UART TX FIFO
// as "HH:MM:SS.CC" followed by a line terminator, one byte per non-full cycle.
//
// Optional build macro: TIME_REPORT_CRLF_EN
//   defined   -> terminator 0D 0A, 13 bytes per line
//   undefined -> terminator 0A,    12 bytes per line
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   trigger         single-cycle report request
//   hour/min/sec    binary time fields (5/6/6 bits)
//   msec            centiseconds, binary (7 bits, values >99 saturate to 99)
//   tx_full         TX FIFO full flag
//   tx_push         FIFO write strobe (combinational, gated by tx_full)
//   tx_data         byte to write, valid with tx_push
//   busy            high from LOAD through the last byte of the line
//   dropped         registered pulse for a trigger ignored while busy
module time_report_tx (
  input  logic       clk,
  input  logic       rst,
  input  logic       trigger,
  input  logic [4:0] hour,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic [6:0] msec,
  input  logic       tx_full,
  output logic       tx_push,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       dropped
);

  localparam logic [7:0] FIELD_SEP = 8'h3A;
  localparam logic [7:0] DEC_SEP   = 8'h2E;

`ifdef TIME_REPORT_CRLF_EN
  localparam int N = 13;
`else
  localparam int N = 12;
`endif
  localparam logic [3:0] LAST_IDX = 4'(N - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  state_t      state_q, state_d;
  logic [4:0]  hour_q, hour_d;
  logic [5:0]  min_q, min_d;
  logic [5:0]  sec_q, sec_d;
  logic [6:0]  msec_q, msec_d;
  // digit order: [7]=H1 [6]=H0 [5]=M1 [4]=M0 [3]=S1 [2]=S0 [1]=C1 [0]=C0
  logic [7:0][3:0] dig_q, dig_d;
  logic [3:0]  idx_q, idx_d;
  logic        dropped_q, dropped_d;
  logic [7:0]  byte_sel;

  // Binary (0..127) to two BCD digits without a divider: tens is the highest
  // multiple of ten not above v; ones only needs the low nibble because the
  // true remainder is below ten, so modulo-16 arithmetic gives it exactly.
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'd0;
    for (int i = 1; i <= 9; i++) begin
      if (v >= 7'(10 * i)) tens = 4'(i);
    end
    ones = v[3:0] - tens * 4'd10;
    if (v > 7'd99) return 8'h99;
    return {tens, ones};
  endfunction

  // Byte decode straight from registered digits and index.
  always_comb begin
    byte_sel = 8'h00;
    case (idx_q)
      4'd0:  byte_sel = {4'h3, dig_q[7]};
      4'd1:  byte_sel = {4'h3, dig_q[6]};
      4'd2:  byte_sel = FIELD_SEP;
      4'd3:  byte_sel = {4'h3, dig_q[5]};
      4'd4:  byte_sel = {4'h3, dig_q[4]};
      4'd5:  byte_sel = FIELD_SEP;
      4'd6:  byte_sel = {4'h3, dig_q[3]};
      4'd7:  byte_sel = {4'h3, dig_q[2]};
      4'd8:  byte_sel = DEC_SEP;
      4'd9:  byte_sel = {4'h3, dig_q[1]};
      4'd10: byte_sel = {4'h3, dig_q[0]};
`ifdef TIME_REPORT_CRLF_EN
      4'd11: byte_sel = 8'h0D;
      4'd12: byte_sel = 8'h0A;
`else
      4'd11: byte_sel = 8'h0A;
`endif
      default: byte_sel = 8'h00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    hour_d    = hour_q;
    min_d     = min_q;
    sec_d     = sec_q;
    msec_d    = msec_q;
    dig_d     = dig_q;
    idx_d     = idx_q;
    dropped_d = trigger && (state_q != IDLE);
    tx_push   = 1'b0;
    tx_data   = 8'h00;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = LOAD;
          hour_d  = hour;
          min_d   = min;
          sec_d   = sec;
          msec_d  = msec;
        end
      end
      LOAD: begin
        {dig_d[7], dig_d[6]} = to_bcd({2'b00, hour_q});
        {dig_d[5], dig_d[4]} = to_bcd({1'b0, min_q});
        {dig_d[3], dig_d[2]} = to_bcd({1'b0, sec_q});
        {dig_d[1], dig_d[0]} = to_bcd(msec_q);
        idx_d   = 4'd0;
        state_d = SEND;
      end
      SEND: begin
        tx_data = byte_sel;
        tx_push = !tx_full;
        if (tx_push) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = 4'd0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dropped = dropped_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      hour_q    <= '0;
      min_q     <= '0;
      sec_q     <= '0;
      msec_q    <= '0;
      dig_q     <= '0;
      idx_q     <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hour_q    <= hour_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      msec_q    <= msec_d;
      dig_q     <= dig_d;
      idx_q     <= idx_d;
      dropped_q <= dropped_d;
    end
  end

endmodule

// File: doc/time_report_tx.md
# time_report_tx

Formats a snapshot of the stopwatch/watch time (hour, min, sec, centisecond) as an ASCII line "HH:MM:SS.CC" plus line terminator and pushes it byte by byte into the UART TX FIFO. It sits between the time datapath outputs and the TX FIFO write port. It is the outbound counterpart to the command path that decodes received UART bytes into run/stop/clear controls. One `trigger` pulse produces one complete line. Writes are flow-controlled by the FIFO full flag.

## Interface
- `FIELD_SEP`, 8'h3A: separator byte after HH and MM (':').
- `DEC_SEP`, 8'h2E: separator byte between SS and CC ('.').
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `trigger`  in  1  single-cycle report request (decoded RX command or periodic tick).
- `hour`  in  5  hours, binary.
- `min`  in  6  minutes, binary.
- `sec`  in  6  seconds, binary.
- `msec`  in  7  centiseconds, binary.
- `tx_full`  in  1  TX FIFO full flag.
- `tx_push`  out  1  FIFO write strobe; one byte is written per cycle in which it is high.
- `tx_data`  out  8  byte to write; valid whenever `tx_push`=1.
- `busy`  out  1  high from LOAD through the last byte of the line.
- `dropped`  out  1  one-cycle pulse when a `trigger` is ignored.

## Operation
- FSM states: IDLE, LOAD, SEND.
- IDLE:
  - `trigger`=1 → LOAD.
  - On the same edge, capture `hour`/`min`/`sec`/`msec` into snapshot registers.
- LOAD (exactly 1 cycle):
  - Convert each snapshot field to two BCD digits, registered.
  - Clear the byte index `idx` to 0.
  - → SEND.
- Conversion rule, per field v:
  - tens = floor(v/10), ones = v − 10·tens.
  - If v > 99 (only `msec` 100..127 can reach this), the field saturates to digits 9,9.
  - Digit byte = 8'h30 + digit.
  - No `/` or `%` operators; use a compare/subtract chain or a constant lookup.
- Byte sequence, index 0..N−1: H1 H0 FIELD_SEP M1 M0 FIELD_SEP S1 S0 DEC_SEP C1 C0, then the terminator (see Configuration).
- SEND:
  - `tx_push` = !`tx_full` (combinational).
  - `tx_data` = byte[`idx`], decoded from registers only.
  - Each cycle with `tx_push`=1: `idx` increments.
  - After the push of byte N−1 → IDLE.
  - While `tx_full`=1: `idx`, `tx_data` and the snapshot hold; no push.
- `trigger` while `busy`=1 is ignored: `dropped`=1 for that cycle. No queuing.
- Input fields may change freely after capture; the line always reflects the snapshot.

## Timing
- Reset values: state IDLE, `tx_push`=0, `tx_data`=8'h00, `busy`=0, `dropped`=0, snapshot=0, `idx`=0.
- Reset mid-line:
  - Outputs go to reset values immediately (asynchronous).
  - The partial line is abandoned, not resumed.
- With `trigger` sampled at edge k:
  - LOAD occupies cycle k+1.
  - The first push is in cycle k+2 if `tx_full`=0.
  - With no backpressure, the last byte is pushed in cycle k+1+N.
  - `busy` is high in cycles k+1 .. k+1+N.
  - IDLE again in cycle k+2+N.
- Earliest accepted re-trigger: edge k+2+N; a trigger there loads immediately.
- `tx_full` is honoured combinationally in the same cycle. A byte is never pushed while `tx_full`=1.
- `tx_data` is stable throughout a stall.
- `dropped` is registered: the pulse appears in the cycle after the ignored `trigger` edge.

## Configuration
- Macro: `TIME_REPORT_CRLF_EN`.
- Defined: terminator is 8'h0D 8'h0A, N=13.
- Undefined: terminator is 8'h0A only, N=12.
- All timing formulas use the configured N.

## Test plan
- Basic line:
  - Stimulus: hour=12, min=34, sec=56, msec=78, pulse `trigger`, `tx_full`=0, CRLF enabled.
  - Required: bytes 31 32 3A 33 34 3A 35 36 2E 37 38 0D 0A in 13 consecutive cycles starting 2 cycles after trigger. `busy` high for 14 cycles.
- Zero/saturation:
  - Stimulus: hour=0, min=0, sec=9, msec=127.
  - Required: line "00:00:09.99".
  - Repeat with hour=23, min=59, sec=59, msec=99 → "23:59:59.99".
- Backpressure:
  - Stimulus: assert `tx_full` during bytes 3..5 for 4 cycles.
  - Required: no push while full, `tx_data` held at 8'h33, no byte lost or duplicated, completion delayed exactly 4 cycles.
- Snapshot:
  - Stimulus: change all time inputs every cycle after trigger.
  - Required: the output equals the values present at the trigger edge.
- Re-trigger:
  - Stimulus: trigger again at byte 5.
  - Required: `dropped` pulses once, a single line is emitted.
  - Stimulus: trigger on the first IDLE cycle.
  - Required: a second full line follows with 1 idle cycle plus the LOAD cycle between lines.
- Reset mid-line:
  - Stimulus: assert `rst` at byte 7, then release and trigger.
  - Required: `tx_push` drops immediately, then a complete fresh line with index starting at byte 0.
  - With the macro undefined: line ends 2E C1 C0 0A, N=12.
